eth_framer: RTL and testbench

- Transmit-side MAC framer.
- Takes a header (dst MAC, src MAC, EtherType) and a byte-wide payload stream, and drives GMII TX signals.
- Emits preamble, SFD, header, payload, zero padding to the minimum frame size, and the IEEE 802.3 FCS, then enforces the inter-packet gap.
- Counterpart of the RX parser; sits between the TX payload source and the GMII TX pins/PHY.

---
 rtl/eth_framer.sv | 204 ++++++++++++++++++++
 tb/tb_eth_framer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_framer.sv
// GMII transmit framer: preamble, SFD, header, payload, zero pad, CRC-32 FCS, inter-packet gap.
// The state names the byte being loaded into the registered GMII outputs during that cycle.
module eth_framer #(
    parameter int PREAMBLE_LEN    = 7,
    parameter int MIN_PAYLOAD_LEN = 46,
    parameter int MAX_PAYLOAD_LEN = 1500,
    parameter int IPG_LEN         = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] dst_mac_i,
    input  logic [47:0] src_mac_i,
    input  logic [15:0] ether_type_i,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [7:0]  gmii_tx_data_o,
    output logic        gmii_tx_en_o,
    output logic        gmii_tx_er_o,
    output logic        busy_o,
    output logic        underrun_o,
    output logic        oversize_o
);
    localparam int PW = $clog2(MAX_PAYLOAD_LEN + 1);
    localparam int CW = $clog2(PREAMBLE_LEN + IPG_LEN + 16);

    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 2);
    localparam logic [CW-1:0] IPG_LAST = CW'(IPG_LEN - 1);
    localparam logic [PW-1:0] MIN_LAST = PW'(MIN_PAYLOAD_LEN - 1);
    localparam logic [PW-1:0] MAX_CNT  = PW'(MAX_PAYLOAD_LEN);
    localparam logic [31:0]   CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, DST_MAC, SRC_MAC, ETHER_TYPE,
        PAYLOAD, PAD, FCS, DRAIN, IPG
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pay_q, pay_d;
    logic [111:0]   hdr_q, hdr_d;
    logic [31:0]    crc_q, crc_d;
    logic [7:0]     data_d;
    logic           en_d, er_d, und_d, ovs_d;
    logic [31:0]    fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign fcs    = ~crc_q;
    assign busy_o = (state_q != IDLE);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_d     = pay_q;
        hdr_d     = hdr_q;
        crc_d     = crc_q;
        data_d    = 8'h00;
        en_d      = 1'b0;
        er_d      = 1'b0;
        und_d     = 1'b0;
        ovs_d     = 1'b0;
        s_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pay_d = '0;
                crc_d = CRC_INIT;
                // The start cycle already loads the first preamble byte.
                if (s_valid_i) begin
                    hdr_d   = {dst_mac_i, src_mac_i, ether_type_i};
                    data_d  = 8'h55;
                    en_d    = 1'b1;
                    state_d = (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
                end
            end
            PREAMBLE: begin
                data_d = 8'h55;
                en_d   = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = SFD;
                end
            end
            SFD: begin
                data_d  = 8'hD5;
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = DST_MAC;
            end
            DST_MAC, SRC_MAC, ETHER_TYPE: begin
                // cnt runs 0..13 across the whole 14-byte header.
                data_d = hdr_q[111:104];
                en_d   = 1'b1;
                hdr_d  = hdr_q << 8;
                crc_d  = crc_byte(crc_q, hdr_q[111:104]);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(5))  state_d = SRC_MAC;
                if (cnt_q == CW'(11)) state_d = ETHER_TYPE;
                if (cnt_q == CW'(13)) begin
                    cnt_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_ready_o = 1'b1;
                en_d      = 1'b1;
                if (s_valid_i) begin
                    data_d = s_data_i;
                    crc_d  = crc_byte(crc_q, s_data_i);
                    pay_d  = pay_q + 1'b1;
                    cnt_d  = '0;
                    if (s_last_i)
                        state_d = (pay_q < MIN_LAST) ? PAD : FCS;
                    else if (pay_d == MAX_CNT)
                        state_d = DRAIN;
                end else begin
                    er_d    = 1'b1;
                    und_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IPG;
                end
            end
            PAD: begin
                en_d  = 1'b1;
                crc_d = crc_byte(crc_q, 8'h00);
                pay_d = pay_q + 1'b1;
                if (pay_q == MIN_LAST) begin
                    cnt_d   = '0;
                    state_d = FCS;
                end
            end
            FCS: begin
                data_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
                en_d   = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(3)) begin
                    cnt_d   = '0;
                    state_d = IPG;
                end
            end
            DRAIN: begin
                // First drain cycle carries the abort marker after the last sent byte.
                s_ready_o = 1'b1;
                cnt_d     = CW'(1);
                if (cnt_q == '0) begin
                    en_d  = 1'b1;
                    er_d  = 1'b1;
                    ovs_d = 1'b1;
                end
                if (s_valid_i && s_last_i) begin
                    cnt_d   = '0;
                    state_d = IPG;
                end
            end
            IPG: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IPG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pay_q          <= '0;
            hdr_q          <= '0;
            crc_q          <= CRC_INIT;
            gmii_tx_data_o <= 8'h00;
            gmii_tx_en_o   <= 1'b0;
            gmii_tx_er_o   <= 1'b0;
            underrun_o     <= 1'b0;
            oversize_o     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pay_q          <= pay_d;
            hdr_q          <= hdr_d;
            crc_q          <= crc_d;
            gmii_tx_data_o <= data_d;
            gmii_tx_en_o   <= en_d;
            gmii_tx_er_o   <= er_d;
            underrun_o     <= und_d;
            oversize_o     <= ovs_d;
        end
    end

endmodule

// File: tb/tb_eth_framer.sv
// Self-checking bench for eth_framer: a frame-level model predicts every output cycle,
// plus literal checks on burst lengths, FCS residue and the mid-frame reset.
module tb_eth_framer;
    localparam int PRE  = 7;
    localparam int MINP = 46;
    localparam int MAXP = 1500;
    localparam int IPG  = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ether_type;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  s_data;
    logic [7:0]  tx_data;
    logic        tx_en, tx_er, busy, underrun, oversize;

    always #4 clk = ~clk;

    eth_framer #(
        .PREAMBLE_LEN(PRE), .MIN_PAYLOAD_LEN(MINP),
        .MAX_PAYLOAD_LEN(MAXP), .IPG_LEN(IPG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dst_mac_i(dst_mac), .src_mac_i(src_mac), .ether_type_i(ether_type),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
        .gmii_tx_data_o(tx_data), .gmii_tx_en_o(tx_en), .gmii_tx_er_o(tx_er),
        .busy_o(busy), .underrun_o(underrun), .oversize_o(oversize)
    );

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
        logic       busy;
        logic       und;
        logic       ovs;
    } cyc_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        int          off;
        int          len;
        int          stall;
    } frame_t;

    cyc_t        exp_q[$];
    logic [7:0]  pay_mem[$];
    frame_t      frames[10];
    int          run_len[$];
    logic [31:0] run_res[$];
    logic [31:0] crc_tab[256];
    int          checks = 0;
    int          errors = 0;
    bit          run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    function automatic cyc_t mk(input logic en, input logic er, input logic [7:0] d,
                                input logic bz, input logic und, input logic ovs);
        return {en, er, d, bz, und, ovs};
    endfunction

    // Frame-level model: start cycle, GMII burst, then the idle tail up to the next IDLE cycle.
    function automatic void model_frame(input int fi);
        frame_t      f;
        logic [111:0] h;
        logic [31:0] c;
        logic [31:0] x;
        f = frames[fi];
        c = 32'hFFFF_FFFF;
        exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < PRE; i++) exp_q.push_back(mk(1, 0, 8'h55, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 8'hD5, 1, 0, 0));
        h = {f.dst, f.src, f.typ};
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(mk(1, 0, h[111:104], 1, 0, 0));
            c = crc_upd(c, h[111:104]);
            h = h << 8;
        end
        if (f.stall >= 0) begin
            for (int k = 0; k < f.stall; k++) exp_q.push_back(mk(1, 0, pay_mem[f.off + k], 1, 0, 0));
            exp_q.push_back(mk(1, 1, 8'h00, 1, 1, 0));
            for (int k = 0; k < IPG - 1; k++) exp_q.push_back(mk(0, 0, 8'h00, 1, 0, 0));
        end else if (f.len > MAXP) begin
            for (int k = 0; k < MAXP; k++) exp_q.push_back(mk(1, 0, pay_mem[f.off + k], 1, 0, 0));
            exp_q.push_back(mk(1, 1, 8'h00, 1, 0, 1));
            for (int k = 0; k < (f.len - MAXP - 1) + IPG - 1; k++)
                exp_q.push_back(mk(0, 0, 8'h00, 1, 0, 0));
        end else begin
            for (int k = 0; k < f.len; k++) begin
                exp_q.push_back(mk(1, 0, pay_mem[f.off + k], 1, 0, 0));
                c = crc_upd(c, pay_mem[f.off + k]);
            end
            for (int k = f.len; k < MINP; k++) begin
                exp_q.push_back(mk(1, 0, 8'h00, 1, 0, 0));
                c = crc_upd(c, 8'h00);
            end
            x = ~c;
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(mk(1, 0, x[7:0], 1, 0, 0));
                x = x >> 8;
            end
            for (int k = 0; k < IPG - 1; k++) exp_q.push_back(mk(0, 0, 8'h00, 1, 0, 0));
        end
    endfunction

    task automatic make_frame(input int fi, input int len, input int stall);
        frames[fi].dst   = 48'({$urandom(), $urandom()});
        frames[fi].src   = 48'({$urandom(), $urandom()});
        frames[fi].typ   = 16'($urandom());
        frames[fi].off   = pay_mem.size();
        frames[fi].len   = len;
        frames[fi].stall = stall;
        for (int k = 0; k < len; k++) pay_mem.push_back(8'($urandom()));
    endtask

    task automatic send_frame(input int fi);
        frame_t f;
        bit     hs;
        int     i;
        int     guard;
        f = frames[fi];
        @(negedge clk);
        dst_mac    = f.dst;
        src_mac    = f.src;
        ether_type = f.typ;
        s_valid    = 1'b1;
        s_data     = pay_mem[f.off];
        s_last     = (f.len == 1) && (f.stall < 0);
        i = 0;
        guard = 0;
        while (i < f.len) begin
            hs = s_ready;
            @(negedge clk);
            guard++;
            if (guard > 4000) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout frame %0d: accepted %0d of %0d", fi, i, f.len);
                break;
            end
            if (hs) begin
                i++;
                if (i == 1) begin
                    dst_mac    = 48'({$urandom(), $urandom()});
                    src_mac    = 48'({$urandom(), $urandom()});
                    ether_type = 16'($urandom());
                end
                if (i < f.len) begin
                    s_data = pay_mem[f.off + i];
                    s_last = (i == f.len - 1) && (f.stall < 0);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (f.stall >= 0) @(negedge clk);
    endtask

    task automatic run_phase(input int first, input int last);
        for (int fi = first; fi <= last; fi++) model_frame(fi);
        for (int k = 0; k < 6; k++) exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0));
        @(posedge clk);
        run = 1;
        for (int fi = first; fi <= last; fi++) send_frame(fi);
        for (int c = 0; c < 20000 && run; c++) @(posedge clk);
        check("phase_timeout", {31'd0, run}, 32'd0);
        run = 0;
    endtask

    // Compare process: one model entry per cycle, plus en-burst lengths and FCS residues.
    initial begin
        cyc_t        e;
        cyc_t        act;
        int          idx;
        bit          in_run;
        int          rlen;
        bit          had_er;
        logic [31:0] mcrc;
        idx = 0;
        in_run = 0;
        rlen = 0;
        had_er = 0;
        mcrc = 32'hFFFF_FFFF;
        forever begin
            @(negedge clk);
            if (run) begin
                if (exp_q.size() == 0) begin
                    run = 0;
                end else begin
                    e   = exp_q.pop_front();
                    act = {tx_en, tx_er, tx_data, busy, underrun, oversize};
                    check($sformatf("cycle%0d {en,er,data,busy,und,ovs}", idx), 32'(act), 32'(e));
                    idx++;
                    if (tx_en) begin
                        if (!in_run) begin
                            in_run = 1;
                            rlen   = 0;
                            had_er = 0;
                            mcrc   = 32'hFFFF_FFFF;
                        end
                        if (rlen >= PRE + 1) mcrc = crc_upd(mcrc, tx_data);
                        rlen++;
                        had_er = had_er | tx_er;
                    end else if (in_run) begin
                        in_run = 0;
                        run_len.push_back(rlen);
                        run_res.push_back(had_er ? 32'd0 : mcrc);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  msg[9];
        logic [31:0] c;
        int          n;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[i] = c;
        end
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = crc_upd(c, msg[i]);
        check("model_crc_123456789", ~c, 32'hCBF4_3926);

        rst_n = 1'b0;
        dst_mac = '0; src_mac = '0; ether_type = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, tx_en, tx_er, busy, underrun, oversize, s_ready, 2'b00}, 32'd0);
        check("reset_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;

        // Phase 1 stimulus: fixed 46-byte frame, then boundary and random frames.
        make_frame(0, 46, -1);
        frames[0].dst = 48'h0123_4567_89AB;
        frames[0].src = 48'h02AA_BBCC_DDEE;
        frames[0].typ = 16'h0800;
        for (int k = 0; k < 46; k++) pay_mem[frames[0].off + k] = 8'(k);
        make_frame(1, 10, -1);
        make_frame(2, 1500, -1);
        make_frame(3, 1501, -1);
        make_frame(4, 20, 20);
        for (int fi = 5; fi < 9; fi++) make_frame(fi, int'($urandom_range(1, 120)), -1);

        model_frame(0);
        check("model_pin_preamble", {24'd0, exp_q[1].d}, 32'h55);
        check("model_pin_sfd", {24'd0, exp_q[8].d}, 32'hD5);
        check("model_pin_dst0", {24'd0, exp_q[9].d}, 32'h01);
        check("model_pin_src0", {24'd0, exp_q[15].d}, 32'h02);
        check("model_pin_type", {16'd0, exp_q[21].d, exp_q[22].d}, 32'h0800);
        check("model_pin_pay45", {24'd0, exp_q[68].d}, 32'h2D);
        exp_q.delete();

        run_phase(0, 8);

        check("burst_count", 32'(run_len.size()), 32'd9);
        check("len_46B", 32'(run_len[0]), 32'd72);
        check("len_10B_padded", 32'(run_len[1]), 32'd72);
        check("len_1500B", 32'(run_len[2]), 32'd1526);
        check("len_oversize", 32'(run_len[3]), 32'd1523);
        check("len_underrun", 32'(run_len[4]), 32'd43);
        for (int i = 0; i < 3; i++)
            check($sformatf("residue_frame%0d", i), run_res[i], 32'hDEBB_20E3);
        for (int fi = 5; fi < 9; fi++) begin
            n = (frames[fi].len < MINP) ? MINP : frames[fi].len;
            check($sformatf("len_rand_frame%0d", fi), 32'(run_len[fi]), 32'(8 + 14 + n + 4));
            check($sformatf("residue_frame%0d", fi), run_res[fi], 32'hDEBB_20E3);
        end

        // Reset asserted while the source MAC is on the wire.
        @(negedge clk);
        dst_mac = 48'h0123_4567_89AB;
        src_mac = 48'h02AA_BBCC_DDEE;
        ether_type = 16'h0800;
        s_valid = 1'b1;
        s_data = 8'hAA;
        s_last = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_reset_src_byte0", {22'd0, tx_en, busy, tx_data}, {22'd0, 1'b1, 1'b1, 8'h02});
        rst_n = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("midframe_reset_outputs", {24'd0, tx_en, tx_er, busy, underrun, oversize, s_ready, 2'b00}, 32'd0);
        check("midframe_reset_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        make_frame(9, 30, -1);
        run_phase(9, 9);
        check("burst_count_after_reset", 32'(run_len.size()), 32'd10);
        check("len_after_reset", 32'(run_len[9]), 32'd72);
        check("residue_after_reset", run_res[9], 32'hDEBB_20E3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
